// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for piso_tx; the master drives words in,
// the slave (the transmitter) drives the serial stream and status back.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sr;

  modport master (
    output en, din, load_valid,
    input  load_ready, sout, sout_valid, busy, done, sr
  );

  modport slave (
    input  en, din, load_valid,
    output load_ready, sout, sout_valid, busy, done, sr
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: word loads from IDLE, first bit one edge later, one bit per en edge.
// Accepts no new word while shifting (load_ready low); optional even-parity bit under PISO_TX_PARITY_EN.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave bus
);
`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tx_bit;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    tx_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
`ifdef PISO_TX_PARITY_EN
    // sr has already drained to zero once the data bits are out; send the captured parity
    if (bit_cnt_q == CW'(WIDTH)) begin
      tx_bit = parity_q;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
`ifdef PISO_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        done_d       = 1'b0;
        if (bus.load_valid) begin
          sr_d      = bus.din;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
`ifdef PISO_TX_PARITY_EN
          parity_d  = ^bus.din;
`endif
        end
      end
      default: begin
        if (bus.en) begin
          sout_d       = tx_bit;
          sr_d         = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
          sout_valid_d = 1'b1;
          bit_cnt_d    = bit_cnt_q + CW'(1);
          done_d       = 1'b0;
          if (bit_cnt_q == LAST_CNT) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          sout_valid_d = 1'b0;
          done_d       = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef PISO_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.load_ready = (state_q == ST_IDLE);
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sr         = sr_q;
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus; expected bits are
// queued at load time and popped whenever a DUT presents sout_valid.
module tb_piso_tx;
  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  typedef struct packed {
    logic         b;
    logic         last;
    logic [W-1:0] sr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b1;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  piso_tx_if #(.WIDTH(W)) ifa ();
  piso_tx_if #(.WIDTH(W)) ifb ();

  assign ifa.en = en;
  assign ifa.din = din;
  assign ifa.load_valid = load_valid;
  assign ifb.en = en;
  assign ifb.din = din;
  assign ifb.load_valid = load_valid;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(ifa));
  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    logic [W-1:0] sa;
    logic [W-1:0] sb;
    for (int k = 0; k < W; k++) begin
      sa = d << (k + 1);
      sb = d >> (k + 1);
      qa.push_back('{b: d[W-1-k], last: (k == FL - 1), sr: sa});
      qb.push_back('{b: d[k],     last: (k == FL - 1), sr: sb});
    end
`ifdef PISO_TX_PARITY_EN
    qa.push_back('{b: ^d, last: 1'b1, sr: '0});
    qb.push_back('{b: ^d, last: 1'b1, sr: '0});
`endif
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (ifa.sout_valid === 1'b1) begin
      if (qa.size() == 0) chk("a_extra_bit", ifa.sout_valid, 0);
      else begin
        e = qa.pop_front();
        chk("a_sout", ifa.sout, e.b);
        chk("a_done", ifa.done, e.last);
        chk("a_sr", ifa.sr, e.sr);
      end
    end else chk("a_done_novalid", ifa.done, 0);
    if (ifb.sout_valid === 1'b1) begin
      if (qb.size() == 0) chk("b_extra_bit", ifb.sout_valid, 0);
      else begin
        e = qb.pop_front();
        chk("b_sout", ifb.sout, e.b);
        chk("b_done", ifb.done, e.last);
        chk("b_sr", ifb.sr, e.sr);
      end
    end else chk("b_done_novalid", ifb.done, 0);
  endtask

  task automatic load(input logic [W-1:0] d);
    chk("a_load_ready", ifa.load_ready, 1);
    chk("b_load_ready", ifb.load_ready, 1);
    din = d;
    load_valid = 1'b1;
    push_frame(d);
    tick();
    load_valid = 1'b0;
    chk("a_busy_after_load", ifa.busy, 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    chk({tag, "_a_missing"}, qa.size(), 0);
    chk({tag, "_b_missing"}, qb.size(), 0);
    chk({tag, "_a_ready"}, ifa.load_ready, 1);
    chk({tag, "_a_busy"}, ifa.busy, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_sout"}, ifa.sout, 0);
    chk({tag, "_a_sout_valid"}, ifa.sout_valid, 0);
    chk({tag, "_a_busy"}, ifa.busy, 0);
    chk({tag, "_a_done"}, ifa.done, 0);
    chk({tag, "_a_load_ready"}, ifa.load_ready, 1);
    chk({tag, "_a_sr"}, ifa.sr, 0);
    chk({tag, "_b_sout_valid"}, ifb.sout_valid, 0);
    chk({tag, "_b_busy"}, ifb.busy, 0);
    chk({tag, "_b_sr"}, ifb.sr, 0);
  endtask

  initial begin
    // reset with a load request pending: nothing may load
    rst = 1'b1;
    load_valid = 1'b1;
    din = 4'b1111;
    tick();
    chk_reset("rst1");
    tick();
    chk_reset("rst2");
    rst = 1'b0;
    load_valid = 1'b0;
    din = '0;
    tick();
    chk_reset("post_rst");

    // basic frame, back-to-back readiness right after done
    load(4'b1011);
    for (int i = 0; i < FL; i++) tick();
    chk("t2_ready_after_done", ifa.load_ready, 1);
    drain("t2");

    // stall after the 2nd bit
    load(4'b1101);
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stall_valid", ifa.sout_valid, 0);
      chk("t3_stall_hold", ifa.sout, 1);
      chk("t3_stall_busy", ifa.busy, 1);
    end
    en = 1'b1;
    drain("t3");

    // load request while shifting is ignored until IDLE
    load(4'b1011);
    tick();
    din = 4'b0000;
    load_valid = 1'b1;
    chk("t4_ready_busy", ifa.load_ready, 0);
    push_frame(4'b0000);
    for (int i = 0; i < FL - 1; i++) tick();
    chk("t4_ready_last", ifa.load_ready, 1);
    tick();
    load_valid = 1'b0;
    chk("t4_gap_valid", ifa.sout_valid, 0);
    chk("t4_loaded", ifa.busy, 1);
    drain("t4");

    // reset mid-frame discards the rest
    load(4'b1011);
    tick();
    tick();
    rst = 1'b1;
    qa.delete();
    qb.delete();
    tick();
    chk_reset("t5_abort");
    rst = 1'b0;
    tick();
    chk_reset("t5_idle");
    load(4'b0110);
    drain("t5");

    // parity-sensitive words through both bit orders
    load(4'b1001);
    drain("t6a");
    load(4'b1011);
    drain("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
